// File: rtl/fizzbuzz_tx_if.sv
// rtl/fizzbuzz_tx_if.sv - byte handshake between fizzbuzz_tx and uart_tx
interface fizzbuzz_tx_if;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_busy;

    modport master (
        output o_tx_data,
        output o_tx_valid,
        input  i_tx_busy
    );

    modport slave (
        input  o_tx_data,
        input  o_tx_valid,
        output i_tx_busy
    );
endinterface

// File: rtl/fizzbuzz_tx.sv
// rtl/fizzbuzz_tx.sv - FizzBuzz 1..MAX_N ASCII byte generator paced by uart_tx busy
// FIZZBUZZ_CRLF_EN defined: lines end in CR LF; undefined: LF only.
module fizzbuzz_tx #(
    parameter int MAX_N  = 100,
    parameter int DIGITS = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    fizzbuzz_tx_if.master tx,
    output logic          o_busy,
    output logic          o_done
);

    localparam int NW = 4 * DIGITS;
    localparam int CW = $clog2(((DIGITS > 8) ? DIGITS : 8) + 1);

    typedef logic [NW-1:0] bcd_t;
    typedef logic [CW-1:0] chr_t;

    localparam logic [1:0] TOK_BODY = 2'd0;
    localparam logic [1:0] TOK_TERM = 2'd1;
    localparam logic [1:0] TOK_END  = 2'd2;

`ifdef FIZZBUZZ_CRLF_EN
    localparam chr_t TERM_LEN = chr_t'(2);
`else
    localparam chr_t TERM_LEN = chr_t'(1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_WAIT,
        S_ADVANCE,
        S_DONE
    } state_t;

    function automatic bcd_t to_bcd(input int v);
        bcd_t r;
        int   t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r = r | (bcd_t'(t % 10) << (4 * i));
            t = t / 10;
        end
        return r;
    endfunction

    localparam bcd_t BCD_MAX = to_bcd(MAX_N);
    localparam bcd_t BCD_ONE = to_bcd(1);

    function automatic bcd_t bcd_inc(input bcd_t v);
        bcd_t       r;
        bcd_t       src;
        logic       carry;
        logic [3:0] d;
        r     = '0;
        src   = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d   = src[3:0];
            src = src >> 4;
            if (carry) begin
                if (d == 4'd9) begin
                    d = 4'd0;
                end else begin
                    d     = d + 4'd1;
                    carry = 1'b0;
                end
            end
            r = r | (bcd_t'(d) << (4 * i));
        end
        return r;
    endfunction

    // Leading zero digits, never counting the units digit.
    function automatic chr_t lead_zeros(input bcd_t v);
        chr_t z;
        logic found;
        bcd_t s;
        z     = '0;
        found = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            s = v >> (4 * i);
            if (!found && s[3:0] == 4'd0) begin
                z = z + chr_t'(1);
            end else begin
                found = 1'b1;
            end
        end
        return z;
    endfunction

    function automatic chr_t body_len(input bcd_t v, input logic [1:0] m3, input logic [2:0] m5);
        if (m3 == 2'd0 && m5 == 3'd0) begin
            return chr_t'(8);
        end else if (m3 == 2'd0 || m5 == 3'd0) begin
            return chr_t'(4);
        end
        return chr_t'(DIGITS) - lead_zeros(v);
    endfunction

    function automatic logic [7:0] body_byte(input bcd_t v, input logic [1:0] m3,
                                             input logic [2:0] m5, input chr_t chr);
        logic [7:0] fizz_ch;
        logic [7:0] buzz_ch;
        bcd_t       s;
        int         pos;
        case (chr[1:0])
            2'd0:    fizz_ch = 8'h46;
            2'd1:    fizz_ch = 8'h69;
            default: fizz_ch = 8'h7A;
        endcase
        case (chr[1:0])
            2'd0:    buzz_ch = 8'h42;
            2'd1:    buzz_ch = 8'h75;
            default: buzz_ch = 8'h7A;
        endcase
        if (m3 == 2'd0 && m5 == 3'd0) begin
            return (chr < chr_t'(4)) ? fizz_ch : buzz_ch;
        end else if (m3 == 2'd0) begin
            return fizz_ch;
        end else if (m5 == 3'd0) begin
            return buzz_ch;
        end
        pos = DIGITS - 1 - int'(lead_zeros(v)) - int'(chr);
        s   = v >> (4 * pos);
        return 8'h30 + {4'd0, s[3:0]};
    endfunction

    function automatic logic [7:0] byte_at(input bcd_t v, input logic [1:0] m3,
                                           input logic [2:0] m5, input logic [1:0] tok,
                                           input chr_t chr);
        if (tok == TOK_BODY) begin
            return body_byte(v, m3, m5, chr);
        end
`ifdef FIZZBUZZ_CRLF_EN
        return (chr == chr_t'(0)) ? 8'h0D : 8'h0A;
`else
        return 8'h0A;
`endif
    endfunction

    // Cursor position following the byte at {tok, chr}.
    function automatic logic [CW+1:0] cursor_after(input bcd_t v, input logic [1:0] m3,
                                                   input logic [2:0] m5, input logic [1:0] tok,
                                                   input chr_t chr);
        chr_t nx;
        nx = chr + chr_t'(1);
        case (tok)
            TOK_BODY: return (nx == body_len(v, m3, m5)) ? {TOK_TERM, chr_t'(0)} : {TOK_BODY, nx};
            TOK_TERM: return (nx == TERM_LEN) ? {TOK_END, chr_t'(0)} : {TOK_TERM, nx};
            default:  return {TOK_END, chr_t'(0)};
        endcase
    endfunction

    state_t     state;
    bcd_t       n;
    logic [1:0] mod3;
    logic [2:0] mod5;
    logic [1:0] tok;
    chr_t       chr;

    bcd_t          n_inc;
    logic [1:0]    m3_inc;
    logic [2:0]    m5_inc;
    logic [7:0]    cur_byte;
    logic [CW+1:0] cur_after;
    logic [7:0]    adv_byte;
    logic [CW+1:0] adv_after;
    logic [7:0]    start_byte;
    logic [CW+1:0] start_after;

    assign n_inc       = bcd_inc(n);
    assign m3_inc      = (mod3 == 2'd2) ? 2'd0 : mod3 + 2'd1;
    assign m5_inc      = (mod5 == 3'd4) ? 3'd0 : mod5 + 3'd1;
    assign cur_byte    = byte_at(n, mod3, mod5, tok, chr);
    assign cur_after   = cursor_after(n, mod3, mod5, tok, chr);
    assign adv_byte    = byte_at(n_inc, m3_inc, m5_inc, TOK_BODY, chr_t'(0));
    assign adv_after   = cursor_after(n_inc, m3_inc, m5_inc, TOK_BODY, chr_t'(0));
    assign start_byte  = byte_at(BCD_ONE, 2'd1, 3'd1, TOK_BODY, chr_t'(0));
    assign start_after = cursor_after(BCD_ONE, 2'd1, 3'd1, TOK_BODY, chr_t'(0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            n             <= '0;
            mod3          <= 2'd0;
            mod5          <= 3'd0;
            tok           <= TOK_BODY;
            chr           <= '0;
            tx.o_tx_data  <= 8'h00;
            tx.o_tx_valid <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            tx.o_tx_valid <= 1'b0;
            o_done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start && !tx.i_tx_busy) begin
                        n             <= BCD_ONE;
                        mod3          <= 2'd1;
                        mod5          <= 3'd1;
                        tx.o_tx_data  <= start_byte;
                        tx.o_tx_valid <= 1'b1;
                        {tok, chr}    <= start_after;
                        o_busy        <= 1'b1;
                        state         <= S_HOLD;
                    end
                end
                // Gives uart_tx one cycle to raise busy after the strobe.
                S_HOLD: state <= S_WAIT;
                S_WAIT: begin
                    if (!tx.i_tx_busy) begin
                        if (tok != TOK_END) begin
                            tx.o_tx_data  <= cur_byte;
                            tx.o_tx_valid <= 1'b1;
                            {tok, chr}    <= cur_after;
                            state         <= S_HOLD;
                        end else if (n == BCD_MAX) begin
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            state <= S_ADVANCE;
                        end
                    end
                end
                // Busy was already seen low in WAIT, so the new line starts here.
                S_ADVANCE: begin
                    n             <= n_inc;
                    mod3          <= m3_inc;
                    mod5          <= m5_inc;
                    tx.o_tx_data  <= adv_byte;
                    tx.o_tx_valid <= 1'b1;
                    {tok, chr}    <= adv_after;
                    state         <= S_HOLD;
                end
                S_DONE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fizzbuzz_tx.sv
// tb/tb_fizzbuzz_tx.sv - directed self-checking bench for fizzbuzz_tx (MAX_N=15 and MAX_N=100)
module tb_fizzbuzz_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;
    logic start15 = 1'b0;
    logic start100 = 1'b0;
    logic busy15, done15, busy100, done100;

    fizzbuzz_tx_if bus15();
    fizzbuzz_tx_if bus100();

    fizzbuzz_tx #(.MAX_N(15), .DIGITS(3)) dut15 (
        .clk    (clk),
        .rst    (rst),
        .i_start(start15),
        .tx     (bus15),
        .o_busy (busy15),
        .o_done (done15)
    );

    fizzbuzz_tx #(.MAX_N(100), .DIGITS(3)) dut100 (
        .clk    (clk),
        .rst    (rst),
        .i_start(start100),
        .tx     (bus100),
        .o_busy (busy100),
        .o_done (done100)
    );

`ifdef FIZZBUZZ_CRLF_EN
    localparam int EXP15  = 73;
    localparam int EXP100 = 513;
`else
    localparam int EXP15  = 58;
    localparam int EXP100 = 413;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // mode: 0 busy tied low, 1 busy high 20 cycles after each strobe, 2 busy forced high
    int mode15 = 0, mode100 = 0, cnt15 = 0, cnt100 = 0, dcnt15 = 0, dcnt100 = 0;
    logic [7:0] cap15[$];
    logic [7:0] cap100[$];
    int stamp15[$];
    int stamp100[$];
    logic [7:0] exp15[$];
    string term;
    string lines15[15] = '{"1", "2", "Fizz", "4", "Buzz", "Fizz", "7", "8", "Fizz", "Buzz",
                           "11", "Fizz", "13", "14", "FizzBuzz"};
    int    chk_idx[10] = '{1, 10, 19, 20, 90, 91, 97, 98, 99, 100};
    string chk_str[10] = '{"1", "Buzz", "19", "Buzz", "FizzBuzz", "91", "97", "98", "Fizz", "Buzz"};

    always @(negedge clk) begin
        if (bus15.o_tx_valid === 1'b1) begin
            cap15.push_back(bus15.o_tx_data);
            stamp15.push_back(cyc);
        end
        if (bus100.o_tx_valid === 1'b1) begin
            cap100.push_back(bus100.o_tx_data);
            stamp100.push_back(cyc);
        end
        if (done15 === 1'b1) dcnt15++;
        if (done100 === 1'b1) dcnt100++;
        if (mode15 == 1) begin
            if (bus15.o_tx_valid === 1'b1) cnt15 = 20;
            else if (cnt15 > 0) cnt15--;
        end else cnt15 = 0;
        if (mode100 == 1) begin
            if (bus100.o_tx_valid === 1'b1) cnt100 = 20;
            else if (cnt100 > 0) cnt100--;
        end else cnt100 = 0;
        bus15.i_tx_busy  = (mode15 == 2) || (cnt15 > 0);
        bus100.i_tx_busy = (mode100 == 2) || (cnt100 > 0);
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total += 8;
        if (bus15.o_tx_data !== 8'h00) begin bad++; $display("FAIL reset_data15 got %h want 00", bus15.o_tx_data); end
        if (bus15.o_tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid15 got %b want 0", bus15.o_tx_valid); end
        if (busy15 !== 1'b0) begin bad++; $display("FAIL reset_busy15 got %b want 0", busy15); end
        if (done15 !== 1'b0) begin bad++; $display("FAIL reset_done15 got %b want 0", done15); end
        if (bus100.o_tx_data !== 8'h00) begin bad++; $display("FAIL reset_data100 got %h want 00", bus100.o_tx_data); end
        if (bus100.o_tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid100 got %b want 0", bus100.o_tx_valid); end
        if (busy100 !== 1'b0) begin bad++; $display("FAIL reset_busy100 got %b want 0", busy100); end
        if (done100 !== 1'b0) begin bad++; $display("FAIL reset_done100 got %b want 0", done100); end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream15();
        int t;
        cap15.delete(); stamp15.delete(); dcnt15 = 0;
        @(posedge clk);
        #1 mode15 = 1;
        @(negedge clk) start15 = 1'b1;
        @(negedge clk) start15 = 1'b0;
        total += 2;
        if (bus15.o_tx_valid !== 1'b1) begin bad++; $display("FAIL latency_valid15 got %b want 1", bus15.o_tx_valid); end
        if (bus15.o_tx_data !== 8'h31) begin bad++; $display("FAIL latency_data15 got %h want 31", bus15.o_tx_data); end
        t = 0;
        while (cap15.size() < 5 && t < 2000) begin @(negedge clk); t++; end
        start15 = 1'b1;
        @(negedge clk) start15 = 1'b0;
        t = 0;
        while (dcnt15 == 0 && t < 6000) begin @(negedge clk); t++; end
        total++;
        if (dcnt15 == 0) begin bad++; $display("FAIL timeout_stream15 got no done want done"); end
        repeat (4) @(negedge clk);
        total++;
        if (cap15.size() != EXP15) begin bad++; $display("FAIL count15 got %0d want %0d", cap15.size(), EXP15); end
        for (int i = 0; i < cap15.size() && i < exp15.size(); i++) begin
            total++;
            if (cap15[i] !== exp15[i]) begin bad++; $display("FAIL byte15[%0d] got %h want %h", i, cap15[i], exp15[i]); end
        end
        total += 4;
        if (dcnt15 != 1) begin bad++; $display("FAIL done_pulses15 got %0d want 1", dcnt15); end
        if (busy15 !== 1'b0) begin bad++; $display("FAIL busy_after15 got %b want 0", busy15); end
        if (bus15.o_tx_valid !== 1'b0) begin bad++; $display("FAIL valid_after15 got %b want 0", bus15.o_tx_valid); end
        if (bus15.o_tx_data !== 8'h0A) begin bad++; $display("FAIL data_hold15 got %h want 0a", bus15.o_tx_data); end
        @(posedge clk);
        #1 mode15 = 0;
    endtask

    task automatic test_tied_zero100();
        int t;
        int exp_gap;
        string cur;
        string lines[$];
        cap100.delete(); stamp100.delete(); dcnt100 = 0;
        @(negedge clk) start100 = 1'b1;
        @(negedge clk) start100 = 1'b0;
        total += 2;
        if (bus100.o_tx_valid !== 1'b1) begin bad++; $display("FAIL latency_valid100 got %b want 1", bus100.o_tx_valid); end
        if (bus100.o_tx_data !== 8'h31) begin bad++; $display("FAIL latency_data100 got %h want 31", bus100.o_tx_data); end
        t = 0;
        while (dcnt100 == 0 && t < 3000) begin @(negedge clk); t++; end
        total++;
        if (dcnt100 == 0) begin bad++; $display("FAIL timeout_stream100 got no done want done"); end
        repeat (4) @(negedge clk);
        total += 2;
        if (cap100.size() != EXP100) begin bad++; $display("FAIL count100 got %0d want %0d", cap100.size(), EXP100); end
        if (dcnt100 != 1) begin bad++; $display("FAIL done_pulses100 got %0d want 1", dcnt100); end
        for (int i = 1; i < stamp100.size(); i++) begin
            exp_gap = (cap100[i-1] == 8'h0A) ? 3 : 2;
            total++;
            if (stamp100[i] - stamp100[i-1] !== exp_gap) begin
                bad++;
                $display("FAIL gap100[%0d] got %0d want %0d", i, stamp100[i] - stamp100[i-1], exp_gap);
            end
        end
        cur = "";
        for (int i = 0; i < cap100.size(); i++) begin
            if (cap100[i] == 8'h0A) begin
                lines.push_back(cur);
                cur = "";
            end else if (cap100[i] != 8'h0D) begin
                cur = $sformatf("%s%c", cur, cap100[i]);
            end
        end
        total++;
        if (lines.size() != 100) begin bad++; $display("FAIL lines100 got %0d want 100", lines.size()); end
        for (int k = 0; k < 10; k++) begin
            if (chk_idx[k] <= lines.size()) begin
                total++;
                if (lines[chk_idx[k]-1] != chk_str[k]) begin
                    bad++;
                    $display("FAIL line100[%0d] got \"%s\" want \"%s\"", chk_idx[k], lines[chk_idx[k]-1], chk_str[k]);
                end
            end
        end
    endtask

    task automatic test_start_pending();
        int t;
        cap15.delete(); stamp15.delete(); dcnt15 = 0;
        @(posedge clk);
        #1 mode15 = 2;
        @(negedge clk);
        #1 start15 = 1'b1;
        repeat (10) @(negedge clk);
        total += 2;
        if (cap15.size() != 0) begin bad++; $display("FAIL pending_strobes got %0d want 0", cap15.size()); end
        if (busy15 !== 1'b0) begin bad++; $display("FAIL pending_busy got %b want 0", busy15); end
        @(posedge clk);
        #1 mode15 = 0;
        @(negedge clk);
        #1;
        total++;
        if (bus15.o_tx_valid !== 1'b0) begin bad++; $display("FAIL pending_early got %b want 0", bus15.o_tx_valid); end
        @(negedge clk);
        total += 3;
        if (bus15.o_tx_valid !== 1'b1) begin bad++; $display("FAIL pending_valid got %b want 1", bus15.o_tx_valid); end
        if (bus15.o_tx_data !== 8'h31) begin bad++; $display("FAIL pending_data got %h want 31", bus15.o_tx_data); end
        if (busy15 !== 1'b1) begin bad++; $display("FAIL pending_obusy got %b want 1", busy15); end
        start15 = 1'b0;
        t = 0;
        while (dcnt15 == 0 && t < 1000) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        total += 2;
        if (dcnt15 == 0) begin bad++; $display("FAIL timeout_pending got no done want done"); end
        if (cap15.size() != EXP15) begin bad++; $display("FAIL pending_count got %0d want %0d", cap15.size(), EXP15); end
    endtask

    task automatic test_reset_mid();
        int t;
        cap15.delete(); stamp15.delete(); dcnt15 = 0;
        @(negedge clk) start15 = 1'b1;
        @(negedge clk) start15 = 1'b0;
        t = 0;
        while (cap15.size() < 10 && t < 500) begin @(posedge clk); #1; t++; end
        total++;
        if (cap15.size() != 10) begin bad++; $display("FAIL rst_prebytes got %0d want 10", cap15.size()); end
        rst = 1'b0;
        #1;
        total += 5;
        if (bus15.o_tx_data !== 8'h00) begin bad++; $display("FAIL rst_mid_data got %h want 00", bus15.o_tx_data); end
        if (bus15.o_tx_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got %b want 0", bus15.o_tx_valid); end
        if (busy15 !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got %b want 0", busy15); end
        if (done15 !== 1'b0) begin bad++; $display("FAIL rst_mid_done got %b want 0", done15); end
        if (cap15.size() >= 10 && cap15[9] !== exp15[9]) begin bad++; $display("FAIL rst_byte10 got %h want %h", cap15[9], exp15[9]); end
        repeat (5) @(negedge clk);
        total++;
        if (cap15.size() != 10) begin bad++; $display("FAIL rst_extra_strobe got %0d want 10", cap15.size()); end
        @(posedge clk);
        #1 rst = 1'b1;
        cap15.delete(); stamp15.delete(); dcnt15 = 0;
        @(negedge clk) start15 = 1'b1;
        @(negedge clk) start15 = 1'b0;
        total += 2;
        if (bus15.o_tx_valid !== 1'b1) begin bad++; $display("FAIL restart_valid got %b want 1", bus15.o_tx_valid); end
        if (bus15.o_tx_data !== 8'h31) begin bad++; $display("FAIL restart_data got %h want 31", bus15.o_tx_data); end
        t = 0;
        while (dcnt15 == 0 && t < 1000) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        total += 2;
        if (dcnt15 != 1) begin bad++; $display("FAIL restart_done got %0d want 1", dcnt15); end
        if (cap15.size() != EXP15) begin bad++; $display("FAIL restart_count got %0d want %0d", cap15.size(), EXP15); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef FIZZBUZZ_CRLF_EN
        term = "\r\n";
`else
        term = "\n";
`endif
        for (int l = 0; l < 15; l++) begin
            for (int c = 0; c < lines15[l].len(); c++) exp15.push_back(lines15[l][c]);
            for (int c = 0; c < term.len(); c++) exp15.push_back(term[c]);
        end
        test_reset();
        test_stream15();
        test_tied_zero100();
        test_start_pending();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
